// File: rtl/alu_pkg.sv
// Shared types for the alu_sv command front end: opcodes, the queued
// command word and the sequencer state encoding.
package alu_pkg;

   // Operand width of the queued command word; the sequencer WIDTH must match.
   localparam int CMD_W = 4;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } alu_op_t;

   typedef struct packed {
      alu_op_t          op;
      logic             use_acc;
      logic [CMD_W-1:0] a;
      logic [CMD_W-1:0] b;
   } alu_cmd_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_STALL = 2'b10
   } seq_state_t;

endpackage

// File: rtl/alu_sv.sv
// Shared combinational ALU: ADD, SUB (carry is the borrow), AND, OR.
module alu_sv
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [1:0]       i_opcode,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry,
   output logic             o_zero
);

   // Arithmetic is done one bit wider so the top bit is the carry or borrow.
   always_comb begin
      o_result = '0;
      o_carry  = 1'b0;
      case (i_opcode)
         OP_ADD:  {o_carry, o_result} = {1'b0, i_a} + {1'b0, i_b};
         OP_SUB:  {o_carry, o_result} = {1'b0, i_a} - {1'b0, i_b};
         OP_AND:  o_result = i_a & i_b;
         default: o_result = i_a | i_b;
      endcase
   end

   assign o_zero = (o_result == '0);

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count; head is read
// combinationally so the consumer sees it in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // Storage array is not reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front end for alu_sv: queues commands, issues the FIFO head to the
// ALU, and registers each result into a valid/ready stream plus accumulator.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [1:0]       i_cmd_op,
   input  logic [WIDTH-1:0] i_cmd_a,
   input  logic [WIDTH-1:0] i_cmd_b,
   input  logic             i_cmd_use_acc,
   output logic [1:0]       o_alu_opcode,
   output logic [WIDTH-1:0] o_alu_a,
   output logic [WIDTH-1:0] o_alu_b,
   input  logic [WIDTH-1:0] i_alu_result,
   input  logic             i_alu_carry,
   input  logic             i_alu_zero,
   output logic             o_res_valid,
   input  logic             i_res_ready,
   output logic [WIDTH-1:0] o_res_data,
   output logic             o_res_carry,
   output logic             o_res_zero,
   output logic [WIDTH-1:0] o_acc,
   output logic             o_busy
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   alu_cmd_t         push_cmd;
   alu_cmd_t         head;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] next_count;
   logic             accept;
   logic             issue;
   logic             next_res_valid;
   seq_state_t       state;

   assign push_cmd.op      = alu_op_t'(i_cmd_op);
   assign push_cmd.use_acc = i_cmd_use_acc;
   assign push_cmd.a       = i_cmd_a;
   assign push_cmd.b       = i_cmd_b;

   sync_fifo #(
      .WIDTH ($bits(alu_cmd_t)),
      .DEPTH (DEPTH)
   ) u_cmd_fifo (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .push  (accept),
      .pop   (issue),
      .wdata (push_cmd),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Ready comes only from the registered count, so a pop never unblocks a full FIFO early.
   assign o_cmd_ready    = ~fifo_full;
   assign accept         = i_cmd_valid & o_cmd_ready;
   assign issue          = ~fifo_empty & (~o_res_valid | i_res_ready);
   assign next_res_valid = issue | (o_res_valid & ~i_res_ready);
   assign next_count     = fifo_count + CNT_W'(accept) - CNT_W'(issue);
   assign o_busy         = ~fifo_empty | o_res_valid;

   // The ALU sees the FIFO head directly; an empty FIFO drives zeros.
   always_comb begin
      o_alu_opcode = '0;
      o_alu_a      = '0;
      o_alu_b      = '0;
      if (!fifo_empty) begin
         o_alu_opcode = head.op;
         o_alu_a      = head.use_acc ? o_acc : head.a;
         o_alu_b      = head.b;
      end
   end

   // Capture the ALU output on every issue; a consumed result with no new issue empties the slot.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_res_valid <= 1'b0;
         o_res_data  <= '0;
         o_res_carry <= 1'b0;
         o_res_zero  <= 1'b0;
         o_acc       <= '0;
      end else if (issue) begin
         o_res_valid <= 1'b1;
         o_res_data  <= i_alu_result;
         o_res_carry <= i_alu_carry;
         o_res_zero  <= i_alu_zero;
         o_acc       <= i_alu_result;
      end else if (o_res_valid && i_res_ready) begin
         o_res_valid <= 1'b0;
      end
   end

   // Activity state tracked alongside the datapath: idle, running, or stalled on the result stream.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (o_res_valid && !i_res_ready) begin
                  state <= S_STALL;
               end else if (next_count == '0 && !next_res_valid) begin
                  state <= S_IDLE;
               end
            end
            S_STALL: begin
               if (i_res_ready) begin
                  state <= S_RUN;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer driving the real alu_sv, with a scoreboard fed
// by an arithmetic reference model at command-accept time.
module tb_alu_cmd_sequencer;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;
   localparam int MODV  = 1 << WIDTH;

   logic             i_clk;
   logic             i_rst_n;
   logic             i_cmd_valid;
   logic             o_cmd_ready;
   logic [1:0]       i_cmd_op;
   logic [WIDTH-1:0] i_cmd_a;
   logic [WIDTH-1:0] i_cmd_b;
   logic             i_cmd_use_acc;
   logic [1:0]       o_alu_opcode;
   logic [WIDTH-1:0] o_alu_a;
   logic [WIDTH-1:0] o_alu_b;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;
   logic             alu_zero;
   logic             o_res_valid;
   logic             i_res_ready;
   logic [WIDTH-1:0] o_res_data;
   logic             o_res_carry;
   logic             o_res_zero;
   logic [WIDTH-1:0] o_acc;
   logic             o_busy;

   typedef struct {
      int data;
      int carry;
      int zero;
   } exp_t;

   exp_t sb[$];
   int   model_acc;
   int   ready_mode;
   int   tests_run;
   int   tests_failed;

   alu_cmd_sequencer #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_cmd_valid   (i_cmd_valid),
      .o_cmd_ready   (o_cmd_ready),
      .i_cmd_op      (i_cmd_op),
      .i_cmd_a       (i_cmd_a),
      .i_cmd_b       (i_cmd_b),
      .i_cmd_use_acc (i_cmd_use_acc),
      .o_alu_opcode  (o_alu_opcode),
      .o_alu_a       (o_alu_a),
      .o_alu_b       (o_alu_b),
      .i_alu_result  (alu_result),
      .i_alu_carry   (alu_carry),
      .i_alu_zero    (alu_zero),
      .o_res_valid   (o_res_valid),
      .i_res_ready   (i_res_ready),
      .o_res_data    (o_res_data),
      .o_res_carry   (o_res_carry),
      .o_res_zero    (o_res_zero),
      .o_acc         (o_acc),
      .o_busy        (o_busy)
   );

   alu_sv #(
      .WIDTH (WIDTH)
   ) u_alu (
      .i_opcode (o_alu_opcode),
      .i_a      (o_alu_a),
      .i_b      (o_alu_b),
      .o_result (alu_result),
      .o_carry  (alu_carry),
      .o_zero   (alu_zero)
   );

   // 10 ns clock
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Compare one observed value against the bench's expectation.
   task automatic checkOutput(input string name, input int actual, input int expected);
      tests_run++;
      if (actual != expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Reference arithmetic straight from the opcode definitions.
   function automatic exp_t refAlu(input int op, input int a, input int b);
      exp_t e;
      case (op)
         0: begin
            e.data  = (a + b) % MODV;
            e.carry = ((a + b) >= MODV) ? 1 : 0;
         end
         1: begin
            e.data  = (a - b + MODV) % MODV;
            e.carry = (a < b) ? 1 : 0;
         end
         2: begin
            e.data  = a & b;
            e.carry = 0;
         end
         default: begin
            e.data  = a | b;
            e.carry = 0;
         end
      endcase
      e.zero = (e.data == 0) ? 1 : 0;
      return e;
   endfunction

   // Commands execute in acceptance order, so the accumulator seen by each
   // command is simply the result of the previously accepted one.
   task automatic modelAccept(input int op, input int a, input int b, input int use_acc);
      exp_t e;
      e = refAlu(op, (use_acc != 0) ? model_acc : a, b);
      model_acc = e.data;
      sb.push_back(e);
   endtask

   // Offer one command (called at posedge+1) and hold it until accepted.
   task automatic applyStimulus(input int op, input int a, input int b, input int use_acc);
      bit taken;
      taken         = 1'b0;
      i_cmd_valid   = 1'b1;
      i_cmd_op      = 2'(op);
      i_cmd_a       = WIDTH'(a);
      i_cmd_b       = WIDTH'(b);
      i_cmd_use_acc = 1'(use_acc);
      for (int t = 0; t < 100 && !taken; t++) begin
         @(negedge i_clk);
         taken = o_cmd_ready;
         @(posedge i_clk);
         if (taken) begin
            modelAccept(op, a, b, use_acc);
         end
      end
      #1;
      i_cmd_valid = 1'b0;
      if (!taken) begin
         checkOutput("cmd_accept_timeout", 0, 1);
      end
   endtask

   // Bounded wait for the DUT and scoreboard to empty.
   task automatic waitDrain(input string name);
      bit done;
      done = 1'b0;
      for (int t = 0; t < 300 && !done; t++) begin
         @(posedge i_clk);
         #1;
         done = (sb.size() == 0) && !o_busy;
      end
      checkOutput(name, int'(done), 1);
   endtask

   // Result-ready driver: 0 = held low, 1 = held high, 2 = random.
   initial begin
      i_res_ready = 1'b0;
      forever begin
         @(posedge i_clk);
         #2;
         case (ready_mode)
            0:       i_res_ready = 1'b0;
            1:       i_res_ready = 1'b1;
            default: i_res_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: a result visible with ready high is consumed at the next edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (i_rst_n && o_res_valid && i_res_ready) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_result", 1, 0);
            end else begin
               e = sb.pop_front();
               checkOutput("res_data", int'(o_res_data), e.data);
               checkOutput("res_carry", int'(o_res_carry), e.carry);
               checkOutput("res_zero", int'(o_res_zero), e.zero);
               checkOutput("acc", int'(o_acc), e.data);
            end
         end
      end
   end

   // Main sequence: reset, directed test-plan cases, stall/full, reset mid-drain, random.
   initial begin
      int held;
      tests_run     = 0;
      tests_failed  = 0;
      model_acc     = 0;
      ready_mode    = 1;
      i_rst_n       = 1'b0;
      i_cmd_valid   = 1'b0;
      i_cmd_op      = '0;
      i_cmd_a       = '0;
      i_cmd_b       = '0;
      i_cmd_use_acc = 1'b0;

      #3;
      checkOutput("rst_res_valid", int'(o_res_valid), 0);
      checkOutput("rst_acc", int'(o_acc), 0);
      checkOutput("rst_res_data", int'(o_res_data), 0);
      checkOutput("rst_cmd_ready", int'(o_cmd_ready), 1);
      checkOutput("rst_busy", int'(o_busy), 0);
      checkOutput("rst_alu_a", int'(o_alu_a), 0);
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;

      // ADD 7+5: not visible right after accept, visible one edge later.
      applyStimulus(0, 7, 5, 0);
      checkOutput("lat_not_yet_valid", int'(o_res_valid), 0);
      @(posedge i_clk);
      #1;
      checkOutput("lat_valid", int'(o_res_valid), 1);
      checkOutput("lat_data_C", int'(o_res_data), 12);
      checkOutput("lat_acc_C", int'(o_acc), 12);
      waitDrain("drain_add");

      // Back-to-back ADD 9+9 then SUB 3-5, then AND C&3.
      applyStimulus(0, 9, 9, 0);
      applyStimulus(1, 3, 5, 0);
      applyStimulus(2, 12, 3, 0);
      waitDrain("drain_b2b");

      // Accumulator chain 1+2, acc+4, acc|8.
      applyStimulus(0, 1, 2, 0);
      applyStimulus(0, 0, 4, 1);
      applyStimulus(3, 0, 8, 1);
      waitDrain("drain_chain");
      checkOutput("chain_acc_F", int'(o_acc), 15);

      // Stall: five commands with ready low fill the FIFO behind one held result.
      ready_mode = 0;
      @(posedge i_clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         applyStimulus($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15), 0);
      end
      checkOutput("full_cmd_ready", int'(o_cmd_ready), 0);
      checkOutput("full_busy", int'(o_busy), 1);
      held = sb[0].data;
      for (int i = 0; i < 3; i++) begin
         @(posedge i_clk);
         #1;
         checkOutput("stall_valid", int'(o_res_valid), 1);
         checkOutput("stall_data", int'(o_res_data), held);
      end
      ready_mode = 1;
      for (int i = 0; i < 5; i++) begin
         @(posedge i_clk);
      end
      #1;
      checkOutput("drain_rate_sb", sb.size(), 0);
      checkOutput("drain_rate_valid", int'(o_res_valid), 0);

      // Reset in the middle of a drain.
      ready_mode = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15), 0);
      end
      ready_mode = 1;
      @(posedge i_clk);
      #3;
      i_rst_n    = 1'b0;
      ready_mode = 0;
      sb.delete();
      model_acc  = 0;
      #1;
      checkOutput("midrst_res_valid", int'(o_res_valid), 0);
      checkOutput("midrst_acc", int'(o_acc), 0);
      checkOutput("midrst_cmd_ready", int'(o_cmd_ready), 1);
      checkOutput("midrst_busy", int'(o_busy), 0);
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst_n    = 1'b1;
      ready_mode = 1;
      for (int i = 0; i < 4; i++) begin
         @(posedge i_clk);
         #1;
         checkOutput("postrst_no_stale", int'(o_res_valid), 0);
      end

      // use_acc right after reset reads 0.
      applyStimulus(0, 9, 6, 1);
      waitDrain("drain_acc_after_reset");

      // Random commands with random gaps and random downstream readiness.
      ready_mode = 2;
      for (int i = 0; i < 200; i++) begin
         applyStimulus($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15),
                       $urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge i_clk);
            #1;
         end
      end
      ready_mode = 1;
      waitDrain("drain_random");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command front end for the shared `alu_sv` datapath (purely combinational, 2-bit opcode: ADD=00, SUB=01, AND=10, OR=11).
- Buffers operation commands in a small FIFO and issues one per cycle to the ALU ports.
- Registers each ALU result, carry and zero into a valid/ready result stream.
- Keeps an accumulator so that chained operations can use the previous result as operand A.

Parameters:
- WIDTH, 4, operand/result width; must match the attached ALU's WIDTH.
- DEPTH, 4, command FIFO entries; power of two, >= 2.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_cmd_valid  input  1  command present.
- o_cmd_ready  output  1  FIFO can accept a command.
- i_cmd_op  input  2  ALU opcode.
- i_cmd_a  input  WIDTH  operand A.
- i_cmd_b  input  WIDTH  operand B.
- i_cmd_use_acc  input  1  1: operand A is taken from the accumulator; i_cmd_a is ignored.
- o_alu_opcode  output  2  to ALU i_opcode.
- o_alu_a  output  WIDTH  to ALU i_a.
- o_alu_b  output  WIDTH  to ALU i_b.
- i_alu_result  input  WIDTH  from ALU o_result.
- i_alu_carry  input  1  from ALU o_carry.
- i_alu_zero  input  1  from ALU o_zero.
- o_res_valid  output  1  result register holds an unconsumed result.
- i_res_ready  input  1  downstream accepts result.
- o_res_data  output  WIDTH  registered result.
- o_res_carry  output  1  registered carry/borrow.
- o_res_zero  output  1  registered zero flag.
- o_acc  output  WIDTH  accumulator value.
- o_busy  output  1  FIFO non-empty or o_res_valid.

Behaviour:
- Reset (asynchronous, i_rst_n low): FIFO empty; pointers and count 0; o_res_valid 0; o_res_data 0; o_res_carry 0; o_res_zero 0; o_acc 0; state S_IDLE.
  - Consequences: o_cmd_ready = 1 and o_busy = 0 while in reset.
  - Reset mid-operation drops all queued commands and any pending result. No partial issue survives.
- Command accept:
  - A command is accepted when i_cmd_valid & o_cmd_ready.
  - o_cmd_ready = (count != DEPTH), decoded from registered count only. A same-cycle pop does not raise ready when full.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Issue condition: issue = fifo_not_empty & (!o_res_valid | i_res_ready).
  - Only the FIFO head can issue; a command written this cycle cannot issue until the next cycle. Minimum accept-to-o_res_valid latency is 2 cycles.
- ALU drive (combinational from the FIFO head):
  - o_alu_opcode = head.op.
  - o_alu_a = head.use_acc ? o_acc : head.a.
  - o_alu_b = head.b.
  - When the FIFO is empty, all ALU-drive outputs are 0.
- On an issue edge:
  - Head is popped.
  - {o_res_carry, o_res_data, o_res_zero} <= {i_alu_carry, i_alu_result, i_alu_zero}.
  - o_acc <= i_alu_result.
  - o_res_valid <= 1.
- Result handshake:
  - A result is consumed when o_res_valid & i_res_ready.
  - If consumed with no issue, o_res_valid <= 0.
  - If consumed and issuing in the same cycle, o_res_valid stays 1 and the data updates. This gives back-to-back throughput of 1 result per cycle.
  - While o_res_valid & !i_res_ready, the result registers and o_acc hold; no issue occurs.
- FSM (state is derived, but must be registered as an enum):
  - S_IDLE: FIFO empty, no result.
  - S_RUN: issuing or result being consumed.
  - S_STALL: o_res_valid & !i_res_ready.
  - S_IDLE -> S_RUN on first accepted command.
  - S_RUN -> S_STALL when a result is held and ready is low.
  - S_STALL -> S_RUN on i_res_ready.
  - S_RUN -> S_IDLE when the FIFO is empty and o_res_valid is 0 after the edge.
- Arithmetic: all width and carry semantics come from the ALU. SUB carry is the borrow (bit WIDTH of the WIDTH+1-bit difference). AND/OR give carry 0.
- use_acc after reset reads o_acc = 0.

Decomposition:
- Package alu_pkg holds:
  - alu_op_t enum (OP_ADD, OP_SUB, OP_AND, OP_OR, logic [1:0]).
  - alu_cmd_t packed struct {op, use_acc, a, b}.
  - seq_state_t enum.
- Sub-module: sync_fifo (parameterised WIDTH/DEPTH, registered count, full/empty) storing alu_cmd_t.
- Top-level testbench instantiates alu_cmd_sequencer + alu_sv back to back.

Test Plan:
- Reset then ADD a=7 b=5, i_res_ready=1 -> 2 cycles after accept: o_res_valid=1, data=4'hC, carry=0, zero=0, o_acc=4'hC.
- ADD 9+9 then SUB 3-5 back to back, ready=1 -> results on consecutive cycles: (2, carry=1), then (4'hE, carry=1).
- AND C&3 -> data=0, zero=1, carry=0.
- Chain ADD 1+2, then use_acc ADD b=4, then use_acc OR b=8 -> results 3, 7, 4'hF; o_acc=4'hF.
- Hold i_res_ready=0, push 5 commands (DEPTH=4):
  - 1 issues, 4 queue.
  - o_cmd_ready=0 once count=4.
  - Result held stable.
  - Release ready -> remaining 4 drain 1/cycle in order.
- Assert i_rst_n=0 mid-drain -> o_res_valid, o_acc, count immediately 0; o_cmd_ready=1; no stale result after release.
